// File: rtl/mycpu_pkg.sv
// Shared CPU constants: default bus widths and the channel index map used by
// the unified-memory arbiter.
package mycpu_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  localparam int unsigned CH_IF  = 0;
  localparam int unsigned CH_MEM = 1;

endpackage : mycpu_pkg

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]         req,
  input  logic [$clog2(NUM_CH)-1:0] ptr,
  output logic [NUM_CH-1:0]         gnt,
  output logic [$clog2(NUM_CH)-1:0] idx
);

  localparam int unsigned IDX_W = $clog2(NUM_CH);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;
  logic             found;

  always_comb begin
    gnt      = '0;
    idx      = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand     = (32'(ptr) + i) % NUM_CH;
      cand_idx = IDX_W'(cand);
      if (!found && req[cand_idx]) begin
        found         = 1'b1;
        gnt[cand_idx] = 1'b1;
        idx           = cand_idx;
      end
    end
  end

endmodule : rr_arbiter

// File: rtl/mem_arbiter.sv
// Round-robin merge of NUM_CH SRAM request ports onto one single-port SRAM.
// Optional feature macro: MEM_ARB_RDATA_HOLD_EN (per-channel read-data hold).
module mem_arbiter
  import mycpu_pkg::*;
#(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CH-1:0]              ch_req,
  input  logic [NUM_CH*(DATA_W/8)-1:0]   ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]       ch_addr,
  input  logic [NUM_CH*DATA_W-1:0]       ch_wdata,
  output logic [NUM_CH-1:0]              ch_gnt,
  output logic [NUM_CH-1:0]              ch_rvalid,
  output logic [NUM_CH*DATA_W-1:0]       ch_rdata,
  output logic                           mem_en,
  output logic [(DATA_W/8)-1:0]          mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic              rd_pend_q, rd_pend_d;
  logic [IDX_W-1:0]  rd_ch_q, rd_ch_d;
  logic [NUM_CH-1:0] gnt_raw;
  logic [IDX_W-1:0]  idx;
  logic              accept;
  logic              is_rd;

  rr_arbiter #(.NUM_CH(NUM_CH)) u_rr (
    .req (ch_req),
    .ptr (ptr_q),
    .gnt (gnt_raw),
    .idx (idx)
  );

  // Reset forces the grant off so no SRAM access escapes while rst is high.
  assign ch_gnt = rst ? '0 : gnt_raw;
  assign accept = |ch_gnt;

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (accept) begin
      mem_en    = 1'b1;
      mem_we    = ch_we[idx*BE_W +: BE_W];
      mem_addr  = ch_addr[idx*ADDR_W +: ADDR_W];
      mem_wdata = ch_wdata[idx*DATA_W +: DATA_W];
    end
  end

  assign is_rd = accept && (mem_we == '0);

  always_comb begin
    ptr_d     = ptr_q;
    rd_pend_d = is_rd;
    rd_ch_d   = rd_ch_q;
    if (accept) begin
      ptr_d = (idx == IDX_W'(NUM_CH - 1)) ? '0 : idx + IDX_W'(1);
    end
    if (is_rd) begin
      rd_ch_d = idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= '0;
      rd_pend_q <= 1'b0;
      rd_ch_q   <= '0;
    end else begin
      ptr_q     <= ptr_d;
      rd_pend_q <= rd_pend_d;
      rd_ch_q   <= rd_ch_d;
    end
  end

  // A read pending when reset hits is dropped, hence the rst gate.
  always_comb begin
    ch_rvalid = '0;
    if (rd_pend_q && !rst) begin
      ch_rvalid[rd_ch_q] = 1'b1;
    end
  end

`ifdef MEM_ARB_RDATA_HOLD_EN
  logic [NUM_CH-1:0][DATA_W-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q <= '0;
    end else begin
      for (int unsigned k = 0; k < NUM_CH; k++) begin
        if (ch_rvalid[k]) begin
          hold_q[k] <= mem_rdata;
        end
      end
    end
  end

  always_comb begin
    ch_rdata = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      ch_rdata[k*DATA_W +: DATA_W] = ch_rvalid[k] ? mem_rdata : hold_q[k];
    end
  end
`else
  assign ch_rdata = {NUM_CH{mem_rdata}};
`endif

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter with two channels.
module tb_mem_arbiter;
  import mycpu_pkg::*;

  logic        clk;
  logic        rst;
  logic [1:0]  ch_req;
  logic [7:0]  ch_we;
  logic [63:0] ch_addr;
  logic [63:0] ch_wdata;
  logic [1:0]  ch_gnt;
  logic [1:0]  ch_rvalid;
  logic [63:0] ch_rdata;
  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_cmp;
  int n_err;

  mem_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ch_req    (ch_req),
    .ch_we     (ch_we),
    .ch_addr   (ch_addr),
    .ch_wdata  (ch_wdata),
    .ch_gnt    (ch_gnt),
    .ch_rvalid (ch_rvalid),
    .ch_rdata  (ch_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs after the falling edge, then settle before checks.
  task automatic drive(input logic r, input logic [1:0] req,
                       input logic [3:0] we0, input logic [3:0] we1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic [31:0] rd);
    @(negedge clk);
    rst       = r;
    ch_req    = req;
    ch_we     = {we1, we0};
    ch_addr   = {a1, a0};
    ch_wdata  = {wd1, wd0};
    mem_rdata = rd;
    #1;
  endtask

  logic [1:0]  exp_g;
  logic [1:0]  prev_g;
  logic [31:0] exp_hold;

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    ch_req    = '0;
    ch_we     = '0;
    ch_addr   = '0;
    ch_wdata  = '0;
    mem_rdata = '0;

    // Reset held with both channels requesting
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 2'b11, 4'h0, 4'h0, 32'h40, 32'h80, 32'h0, 32'h0, 32'h0);
      chk("rst_gnt", 64'(ch_gnt), 64'h0);
      chk("rst_en", 64'(mem_en), 64'h0);
      chk("rst_rvalid", 64'(ch_rvalid), 64'h0);
      chk("rst_addr", 64'(mem_addr), 64'h0);
      chk("rst_we", 64'(mem_we), 64'h0);
    end

    // Contention from the first post-reset cycle: 0,1,0,1,0,1
    prev_g = 2'b00;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 2'b11, 4'h0, 4'h0, 32'h1000 + 32'(i), 32'h2000 + 32'(i),
            32'h0, 32'h0, 32'hC0DE0000 + 32'(i));
      exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
      chk("cont_gnt", 64'(ch_gnt), 64'(exp_g));
      chk("cont_addr", 64'(mem_addr), (i % 2 == 0) ? 64'h1000 + 64'(i) : 64'h2000 + 64'(i));
      chk("cont_en", 64'(mem_en), 64'h1);
      chk("cont_rvalid", 64'(ch_rvalid), 64'(prev_g));
      if (prev_g == 2'b01) chk("cont_rdata0", 64'(ch_rdata[31:0]), 64'hC0DE0000 + 64'(i));
      if (prev_g == 2'b10) chk("cont_rdata1", 64'(ch_rdata[63:32]), 64'hC0DE0000 + 64'(i));
      prev_g = exp_g;
    end

    // Single read on ch1
    drive(1'b0, 2'b10, 4'h0, 4'h0, 32'h0, 32'h100, 32'h0, 32'h0, 32'h0);
    chk("rd_gnt", 64'(ch_gnt), 64'h2);
    chk("rd_addr", 64'(mem_addr), 64'h100);
    chk("rd_we", 64'(mem_we), 64'h0);
    chk("rd_prev_rvalid", 64'(ch_rvalid), 64'h2);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF);
    chk("rd_rvalid", 64'(ch_rvalid), 64'h2);
    chk("rd_rdata1", 64'(ch_rdata[63:32]), 64'hDEADBEEF);
    chk("idle_gnt", 64'(ch_gnt), 64'h0);
    chk("idle_en", 64'(mem_en), 64'h0);
    chk("idle_addr", 64'(mem_addr), 64'h0);

    // Byte-masked write on ch1
    drive(1'b0, 2'b10, 4'h0, 4'b0011, 32'h0, 32'h20, 32'h0, 32'h12345678, 32'h0);
    chk("wr_gnt", 64'(ch_gnt), 64'h2);
    chk("wr_we", 64'(mem_we), 64'h3);
    chk("wr_addr", 64'(mem_addr), 64'h20);
    chk("wr_wdata", 64'(mem_wdata), 64'h12345678);
    drive(1'b0, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h55555555);
    chk("wr_no_rvalid", 64'(ch_rvalid), 64'h0);
    chk("wr_idle_wdata", 64'(mem_wdata), 64'h0);

    // ch0 read, then ch1 reads while ch0 sits stalled
    drive(1'b0, 2'b01, 4'h0, 4'h0, 32'h8, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("hold_gnt0", 64'(ch_gnt), 64'h1);
    drive(1'b0, 2'b10, 4'h0, 4'h0, 32'h0, 32'h300, 32'h0, 32'h0, 32'hA5A5A5A5);
    chk("hold_rvalid0", 64'(ch_rvalid), 64'h1);
    chk("hold_rdata0", 64'(ch_rdata[31:0]), 64'hA5A5A5A5);
    chk("hold_gnt1", 64'(ch_gnt), 64'h2);
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 2'b10, 4'h0, 4'h0, 32'h0, 32'h300 + 32'(i), 32'h0, 32'h0, 32'h11111111 * 32'(i));
`ifdef MEM_ARB_RDATA_HOLD_EN
      exp_hold = 32'hA5A5A5A5;
`else
      exp_hold = 32'h11111111 * 32'(i);
`endif
      chk("hold_stable0", 64'(ch_rdata[31:0]), 64'(exp_hold));
      chk("hold_rvalid1", 64'(ch_rvalid), 64'h2);
      chk("hold_rdata1", 64'(ch_rdata[63:32]), 64'h11111111 * 64'(i));
    end

    // Reset hits while a ch0 read is pending
    drive(1'b0, 2'b01, 4'h0, 4'h0, 32'h44, 32'h0, 32'h0, 32'h0, 32'h0);
    chk("rmr_gnt0", 64'(ch_gnt), 64'h1);
    drive(1'b1, 2'b00, 4'h0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h77777777);
    chk("rmr_rvalid_in_rst", 64'(ch_rvalid), 64'h0);
    chk("rmr_gnt_in_rst", 64'(ch_gnt), 64'h0);
    drive(1'b0, 2'b11, 4'h0, 4'h0, 32'h50, 32'h60, 32'h0, 32'h0, 32'h99999999);
    chk("rmr_rvalid_after", 64'(ch_rvalid), 64'h0);
    chk("rmr_ptr0", 64'(ch_gnt), 64'h1);
    chk("rmr_addr", 64'(mem_addr), 64'h50);
`ifdef MEM_ARB_RDATA_HOLD_EN
    exp_hold = 32'h0;
`else
    exp_hold = 32'h99999999;
`endif
    chk("rmr_rdata0", 64'(ch_rdata[31:0]), 64'(exp_hold));
    drive(1'b0, 2'b11, 4'h0, 4'h0, 32'h50, 32'h60, 32'h0, 32'h0, 32'h0);
    chk("rmr_next_gnt", 64'(ch_gnt), 64'h2);
    chk("rmr_next_rvalid", 64'(ch_rvalid), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised round-robin arbiter that merges NUM_CH SRAM-style request ports onto one synchronous single-port SRAM. It replaces the separate instruction and data SRAM ports at the CPU top with a single memory port, so the pipeline can run against a unified memory. Each channel sees a grant/stall handshake and a tagged read-data return one cycle after grant.

## Interface
Parameters:
- NUM_CH, 2, number of requesting channels (≥2); channel 0 = instruction fetch, 1 = data by convention
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width BE_W = DATA_W/8

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- ch_req  in  NUM_CH  per-channel request; held until granted
- ch_we  in  NUM_CH*BE_W  per-channel byte write enables; 0 = read
- ch_addr  in  NUM_CH*ADDR_W  per-channel address
- ch_wdata  in  NUM_CH*DATA_W  per-channel write data
- ch_gnt  out  NUM_CH  one-hot grant; requester treats req & !gnt as stall
- ch_rvalid  out  NUM_CH  read data valid for that channel this cycle
- ch_rdata  out  NUM_CH*DATA_W  per-channel read data
- mem_en  out  1  SRAM enable
- mem_we  out  BE_W  SRAM byte write enables
- mem_addr  out  ADDR_W  SRAM address
- mem_wdata  out  DATA_W  SRAM write data
- mem_rdata  in  DATA_W  SRAM read data, valid one cycle after mem_en

## Operation
- Grant is combinational from ch_req and the priority pointer ptr (range 0..NUM_CH-1): first requesting channel at or after ptr, scanning upward with wrap-around.
- At most one ch_gnt bit is high. No request → ch_gnt = 0 and mem_en = 0.
- mem_en/we/addr/wdata carry the granted channel's fields. They are 0 when there is no grant.
- Transaction accepted = ch_req[k] & ch_gnt[k]. On acceptance, ptr ← (k+1) mod NUM_CH. With no acceptance, ptr holds.
- A read is an accepted request with ch_we[k] == 0. For a read, register rd_pend = 1 and rd_ch = k.
- Writes produce no rvalid.
- Next cycle: ch_rvalid[rd_ch] = rd_pend, and ch_rdata[rd_ch] = mem_rdata.
- Fairness: a channel holding req is granted within NUM_CH cycles.
- A new grant and a returning rvalid in the same cycle are independent and both legal, including to the same channel.
- Requester changing addr/we while req is high and ungranted is allowed; the granted cycle's values are used.

## Timing
- Arbitration latency: 0 cycles (grant same cycle as req if ptr favours it).
- Read latency: rvalid exactly 1 cycle after the granting cycle.
- Throughput: one accepted transaction per cycle, back-to-back, any mix of channels.
- While rst = 1: ch_gnt = 0, mem_en = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, ch_rvalid = 0.
- On reset: ptr = 0, rd_pend = 0, hold registers = 0.
- Reset asserted during a pending read: the response is dropped and no rvalid is produced after reset release.
- First cycle after rst deasserts: arbitration is live and ptr = 0.

## Configuration
- MEM_ARB_RDATA_HOLD_EN defined:
  - each channel has a DATA_W hold register, loaded with mem_rdata when that channel's rvalid is high;
  - ch_rdata[k] = ch_rvalid[k] ? mem_rdata : hold[k], so data stays stable while the CPU is stalled.
- Undefined:
  - ch_rdata[k] = mem_rdata for every channel, meaningful only in the rvalid cycle;
  - no hold registers.

## Structure
- Shared package mycpu_pkg: default ADDR_W/DATA_W constants and the channel index constants CH_IF = 0, CH_MEM = 1.
- Sub-module rr_arbiter (NUM_CH):
  - inputs req, ptr; output one-hot gnt plus encoded index;
  - purely combinational; ptr register lives in mem_arbiter.

## Test plan
- Reset: rst = 1 for 3 cycles with ch_req = 2'b11 → ch_gnt = 0, mem_en = 0, ch_rvalid = 0; first post-reset cycle grants ch0.
- Single read: ch1 reads addr 0x100, SRAM returns 0xDEADBEEF → gnt[1] same cycle, mem_addr = 0x100, mem_we = 0; next cycle rvalid[1] = 1 and rdata[1] = 0xDEADBEEF.
- Contention: ch0 and ch1 request continuously for 6 cycles → grants alternate 0,1,0,1,0,1 and rvalid follows one cycle later with matching channel.
- Write: ch1 writes we = 4'b0011, addr 0x20, wdata 0x12345678 → mem_we = 4'b0011, mem_wdata = 0x12345678, no rvalid next cycle.
- Reset mid-read: ch0 read granted, rst asserted next cycle → ch_rvalid stays 0 and ptr returns to 0.
- Hold (MEM_ARB_RDATA_HOLD_EN): ch0 read returns 0xA5A5A5A5, then ch1 traffic for 4 cycles → rdata[0] stays 0xA5A5A5A5; without the macro rdata[0] tracks mem_rdata.
